// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order writeback queue that drains one entry per
// cycle into the register-file write port and forwards pending data.
module regfile_write_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         in_ready,
    output logic                         rf_write,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    input  logic [ADDR_W-1:0]            raddr1,
    input  logic [ADDR_W-1:0]            raddr2,
    output logic                         fwd1_hit,
    output logic [DATA_W-1:0]            fwd1_data,
    output logic                         fwd2_hit,
    output logic [DATA_W-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_pop;
    logic              w_push_mem;
    logic              w_push_alu;
    logic [1:0]        w_npush;
    logic [PW-1:0]     w_alu_slot;
    logic [PW-1:0]     w_idx;
    int                w_slack;

    // Accept rule from registered occupancy; a pop this cycle frees one slot.
    always_comb begin
        w_slack = DEPTH - int'(r_count);
        if (r_count != '0) begin
            w_slack = w_slack + 1;
        end
        in_ready   = !rst && (w_slack >= 2);
        w_pop      = (r_count != '0);
        w_push_mem = in_ready && mem_valid && (mem_addr != '0);
        w_push_alu = in_ready && alu_valid && (alu_addr != '0);
        w_npush    = {1'b0, w_push_mem} + {1'b0, w_push_alu};
        w_alu_slot = w_push_mem ? (r_tail + PW'(1)) : r_tail;
    end

    // Queue storage and pointers; mem goes in ahead of alu (older instruction).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push_mem) begin
                r_addr[r_tail] <= mem_addr;
                r_data[r_tail] <= mem_data;
            end
            if (w_push_alu) begin
                r_addr[w_alu_slot] <= alu_addr;
                r_data[w_alu_slot] <= alu_data;
            end
            r_tail <= r_tail + PW'(w_npush);
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_npush) - CW'(w_pop);
        end
    end

    // Drain port: head entry whenever the queue holds anything.
    always_comb begin
        rf_write = w_pop;
        rf_waddr = w_pop ? r_addr[r_head] : '0;
        rf_wdata = w_pop ? r_data[r_head] : '0;
        count    = r_count;
        empty    = (r_count == '0);
    end

    // Forwarding: walk oldest to youngest from head so the youngest match wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        w_idx     = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (k < int'(r_count)) begin
                if ((raddr1 != '0) && (r_addr[w_idx] == raddr1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = r_data[w_idx];
                end
                if ((raddr2 != '0) && (r_addr[w_idx] == raddr2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = r_data[w_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_regfile_write_queue;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_addr, mem_addr, raddr1, raddr2;
    logic [DW-1:0] alu_data, mem_data;
    logic          in_ready, rf_write, fwd1_hit, fwd2_hit, empty;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, fwd1_data, fwd2_data;
    logic [2:0]    count;

    regfile_write_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .in_ready(in_ready), .rf_write(rf_write),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] wlog[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int n, input bit r);
        int free;
        free = DEPTH - n + ((n != 0) ? 1 : 0);
        return !r && (free >= 2);
    endfunction

    function automatic void m_fwd(input logic [AW-1:0] ra, output bit h,
                                  output logic [DW-1:0] d);
        h = 0;
        d = '0;
        if (ra != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == ra) begin
                    h = 1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    // Reference model: pop the head if any, then accept mem before alu.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            bit rdy;
            rdy = m_ready(mq.size(), 1'b0);
            if (mq.size() > 0) void'(mq.pop_front());
            if (rdy && mem_valid && mem_addr != 0) mq.push_back('{mem_addr, mem_data});
            if (rdy && alu_valid && alu_addr != 0) mq.push_back('{alu_addr, alu_data});
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            bit            h1, h2;
            logic [DW-1:0] d1, d2;
            int            n;
            n = mq.size();
            m_fwd(raddr1, h1, d1);
            m_fwd(raddr2, h2, d2);
            chk("in_ready", in_ready, m_ready(n, rst));
            chk("rf_write", rf_write, n != 0);
            chk("rf_waddr", rf_waddr, (n != 0) ? mq[0].a : '0);
            chk("rf_wdata", rf_wdata, (n != 0) ? mq[0].d : '0);
            chk("count", count, n);
            chk("empty", empty, n == 0);
            chk("fwd1_hit", fwd1_hit, h1);
            chk("fwd1_data", fwd1_data, d1);
            chk("fwd2_hit", fwd2_hit, h2);
            chk("fwd2_data", fwd2_data, d2);
            if (rf_write) wlog.push_back(rf_waddr);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0;
        mem_valid = 0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && count != 0; i++) next();
        n_cmp++;
        if (count != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got count %0d required 0", count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        rst = 1;
        idle();
        alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0;
        raddr1 = 0; raddr2 = 0;
        next();
        chk_en = 1;
        next();
        mid();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rf_write", rf_write, 0);
        next();
        rst = 0;

        // Single write
        alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF; raddr1 = 3;
        next();
        idle();
        mid();
        chk("t1_write", rf_write, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_count", count, 1);
        next();
        mid();
        chk("t1_empty", empty, 1);
        chk("t1_nowrite", rf_write, 0);
        next();

        // Dual same address
        mem_valid = 1; mem_addr = 5; mem_data = 32'h11;
        alu_valid = 1; alu_addr = 5; alu_data = 32'h22; raddr1 = 5;
        next();
        idle();
        mid();
        chk("t2_wdata0", rf_wdata, 32'h11);
        chk("t2_fwd0", fwd1_data, 32'h22);
        next();
        mid();
        chk("t2_wdata1", rf_wdata, 32'h22);
        chk("t2_fwd1", fwd1_data, 32'h22);
        next();
        mid();
        chk("t2_nohit", fwd1_hit, 0);
        next();

        // Register 0 dropped
        mem_valid = 1; mem_addr = 0; alu_valid = 1; alu_addr = 0; raddr2 = 0;
        next();
        idle();
        mid();
        chk("t3_write", rf_write, 0);
        chk("t3_count", count, 0);
        next();

        // Backpressure
        mem_valid = 1; alu_valid = 1; raddr1 = 7;
        for (int i = 0; i < 5; i++) begin
            mem_addr = AW'(6 + 2 * i); mem_data = 32'h1000 + i;
            alu_addr = AW'(7 + 2 * i); alu_data = 32'h2000 + i;
            mid();
            case (i)
                0: chk("t4_c0", {count, in_ready}, {3'd0, 1'b1});
                1: chk("t4_c2", {count, in_ready}, {3'd2, 1'b1});
                2: chk("t4_c3", {count, in_ready}, {3'd3, 1'b1});
                3: chk("t4_c4", {count, in_ready}, {3'd4, 1'b0});
                default: chk("t4_c3b", {count, in_ready}, {3'd3, 1'b1});
            endcase
            if (i < 4) next();
        end
        next();
        drain();

        // Reset mid-operation
        mem_valid = 1; alu_valid = 1;
        mem_addr = 12; mem_data = 32'hA; alu_addr = 13; alu_data = 32'hB;
        next();
        mem_addr = 14; alu_addr = 15;
        next();
        idle();
        raddr1 = 14;
        mid();
        chk("t5_pre", count, 3);
        rst = 1;
        next();
        rst = 0;
        mid();
        chk("t5_count", count, 0);
        chk("t5_write", rf_write, 0);
        chk("t5_hit", fwd1_hit, 0);
        next();

        // Wrap-around with queue partly full
        mem_valid = 1; alu_valid = 1; raddr1 = 9;
        mem_addr = 20; mem_data = 20; alu_addr = 21; alu_data = 21;
        next();
        mem_addr = 22; mem_data = 22; alu_addr = 23; alu_data = 23;
        next();
        mem_valid = 0;
        base = wlog.size();
        for (int a = 1; a <= 10; a++) begin
            alu_addr = AW'(a); alu_data = a * 32'h100;
            next();
            if (a == 9) begin
                mid();
                chk("t6_fwd9_hit", fwd1_hit, 1);
                chk("t6_fwd9_data", fwd1_data, 32'h900);
            end
        end
        drain();
        next();
        k = 0;
        for (int i = base; i < wlog.size(); i++) begin
            if (wlog[i] >= 1 && wlog[i] <= 10) begin
                k++;
                chk("t6_order", wlog[i], k);
            end
        end
        chk("t6_ncommit", k, 10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            mem_valid = 1'($urandom);
            alu_valid = 1'($urandom);
            mem_addr = AW'($urandom_range(0, 7));
            alu_addr = AW'($urandom_range(0, 7));
            mem_data = $urandom;
            alu_data = $urandom;
            raddr1 = AW'($urandom_range(0, 7));
            raddr2 = AW'($urandom_range(0, 7));
            rst = ($urandom_range(0, 63) == 0);
            next();
        end
        rst = 0;
        drain();
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
Initiator side of the register-file write port. It collects writeback requests from the ALU and load (memory) paths, buffers them in an in-order queue, and drains one write per cycle into the single register-file write port (write/waddr/writeData). It also forwards pending, not-yet-committed data to the two register read ports so decode never reads a stale value.

Parameters:
DATA_W, 32, width of register data
ADDR_W, 5, register index width
DEPTH, 4, queue entries; power of two, at least 2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU writeback request
alu_addr  in  ADDR_W  ALU destination register index
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_addr  in  ADDR_W  load destination register index
mem_data  in  DATA_W  load data
in_ready  out  1  requests are accepted this cycle
rf_write  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write index
rf_wdata  out  DATA_W  register-file write data
raddr1  in  ADDR_W  read port 1 index, for forwarding lookup
raddr2  in  ADDR_W  read port 2 index, for forwarding lookup
fwd1_hit  out  1  pending write matches raddr1
fwd1_data  out  DATA_W  youngest pending data for raddr1
fwd2_hit  out  1  pending write matches raddr2
fwd2_data  out  DATA_W  youngest pending data for raddr2
count  out  clog2(DEPTH+1)  queue occupancy
empty  out  1  count == 0

Behaviour:
- **Storage:** circular queue of DEPTH entries {addr, data}, with head/tail pointers and a registered count. Pointers wrap modulo DEPTH.
- **Reset:** rst high at a posedge sets count=0, head=tail=0, clears all entries' valid state. Resulting outputs: rf_write=0, rf_waddr=0, rf_wdata=0, fwd*_hit=0, fwd*_data=0, empty=1.
- **Reset mid-operation:** pending writes are discarded and never reach the register file. While rst is high, in_ready=0.
- **Drain:**
  - rf_write = !empty.
  - rf_waddr/rf_wdata = head entry, driven combinationally from queue registers.
  - Head pops at every posedge where rf_write=1; the register file always accepts.
- **Accept rule:** in_ready = (DEPTH - count + (count != 0)) >= 2, computed from registered count only. When in_ready=0, both requests are ignored and upstream holds them.
- **Push order:** when accepted, mem is enqueued first, then alu (the load belongs to the older instruction). If only one source is valid, only that one is pushed. Up to 2 pushes per cycle.
- **Register 0:** a request whose addr is 0 is dropped: not enqueued, no rf_write, no count change.
- **Latency:**
  - Accepted at edge N; rf_write asserted in cycle N+1 if the queue was empty.
  - Committed to the register file at edge N+1.
  - Readable from the register file after edge N+1.
- **Occupancy:** next count = count + pushes - pop, with pushes in 0..2 and pop in 0..1. count never exceeds DEPTH.
- **Forwarding:**
  - Combinational search over valid queue entries only; incoming same-cycle requests are excluded.
  - The hit is the youngest entry (closest to tail) whose addr equals raddrN.
  - raddrN == 0 never hits.
  - With no hit: fwdN_hit=0 and fwdN_data=0.
  - The head entry being written this cycle still forwards; after the edge, the register file holds the value.
- **Same-address events:**
  - mem and alu with equal addr in one cycle: two entries, committed mem then alu; forwarding returns alu data.
  - Two queued entries with equal addr: the younger one wins forwarding.
- **Wrap-around:** entries keep FIFO order across pointer wrap; forwarding age ordering is computed relative to head, not by raw index.

Test Plan:
1. Single write: empty queue; alu_valid=1, alu_addr=3, alu_data=0xDEADBEEF for one cycle -> next cycle rf_write=1, rf_waddr=3, rf_wdata=0xDEADBEEF, count=1; the cycle after, rf_write=0, empty=1.
2. Dual same address: mem (5, 0x11) and alu (5, 0x22) in one cycle -> rf_write commits 0x11 then 0x22 on consecutive cycles; raddr1=5 gives fwd1_hit=1, fwd1_data=0x22 in both cycles, then fwd1_hit=0.
3. Register 0: alu_addr=0 and mem_addr=0 both valid -> no rf_write, count stays 0; raddr2=0 -> fwd2_hit=0.
4. Backpressure with DEPTH=4: dual pushes every cycle -> count goes 0,2,3,4; in_ready=0 at count=4, and count returns to 3 with requests held; in_ready=1 again.
5. Reset mid-operation: count=3, assert rst for one cycle -> count=0, rf_write=0, fwd hits 0; queued data is never written.
6. Wrap-around: 10 single alu writes (addr 1..10, data = addr × 0x100), with the queue partly full -> commits in exact order; forwarding is correct for addr 9 while it is queued.
